// File: rtl/onoc_rx_pkg.sv
// Shared definitions for the optical-NoC receive front end: FSM states,
// flit geometry and header field positions.
package onoc_rx_pkg;

    localparam int NODE_W = 16;
    localparam int FLIT_W = 32;

    // Header/data payload fields
    localparam int SRC_HI = 31;
    localparam int SRC_LO = 16;
    localparam int CNT_HI = 15;
    localparam int CNT_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DROP,
        ST_REL_HDR,
        ST_REL_DATA
    } rx_state_t;

endpackage

// File: rtl/onoc_rx_fifo.sv
// Synchronous store-and-forward buffer with flush. Pointers wrap at DEPTH,
// so non-power-of-two depths are supported.
module onoc_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rdata = mem[rptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Storage array; contents are don't-care once pointers are flushed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= next_ptr(wptr_q);
            end
            if (pop) begin
                rptr_q <= next_ptr(rptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Packet length is capped at DEPTH upstream, so overflow is impossible
    always_ff @(posedge clk) begin
        if (rst && push) begin
            assert (!full);
        end
    end
`endif

endmodule

// File: rtl/onoc_rx_interface.sv
// Receive front end: filters link flits by destination, buffers a whole
// packet, then replays header + data as one contiguous burst.
// Optional feature macro: ONOC_RX_PARITY_EN (even-parity check on flits).
module onoc_rx_interface
    import onoc_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] node_id,
    input  logic              link_valid,
    input  logic              link_ctrl,
    input  logic [NODE_W-1:0] link_dest,
    input  logic [FLIT_W-1:0] link_payload,
    input  logic              link_parity,
    output logic              link_ready,
    output logic [FLIT_W-1:0] control_rx_packet,
    output logic [FLIT_W-1:0] data_rx_packet,
    output logic              rx_err,
    output logic              rx_busy
);

    localparam logic [NODE_W-1:0] DEPTH_C = NODE_W'(DEPTH);

    rx_state_t         state_q, state_d;
    logic [FLIT_W-1:0] hdr_q, hdr_d;
    logic [NODE_W-1:0] cnt_q, cnt_d;
    logic [NODE_W-1:0] rem_q, rem_d;
    logic [NODE_W-1:0] wcnt_q, wcnt_d;
    logic [FLIT_W-1:0] ctrl_q, ctrl_d;
    logic [FLIT_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              ready_int;
    logic              accept;
    logic              par_ok;
    logic              is_local;
    logic [NODE_W-1:0] flit_cnt;
    logic [NODE_W-1:0] flit_src;

    logic              push, pop, flush;
    logic [FLIT_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;

`ifdef ONOC_RX_PARITY_EN
    assign par_ok = ~^{link_ctrl, link_dest, link_payload, link_parity};
`else
    logic unused_parity;
    assign unused_parity = link_parity;
    assign par_ok        = 1'b1;
`endif

    assign ready_int = (state_q == ST_IDLE) || (state_q == ST_COLLECT) ||
                       (state_q == ST_DROP);
    // Reset gates ready directly so it is low while held and high immediately after release
    assign link_ready = rst & ready_int;
    assign accept     = link_valid & ready_int;
    assign is_local   = (link_dest == node_id);
    assign flit_cnt   = link_payload[CNT_HI:CNT_LO];
    assign flit_src   = link_payload[SRC_HI:SRC_LO];

    assign control_rx_packet = ctrl_q;
    assign data_rx_packet    = data_q;
    assign rx_err            = err_q;
    assign rx_busy           = (state_q != ST_IDLE);

    onoc_rx_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(FLIT_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .wdata(link_payload),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; output registers load on the edge entering the presenting state
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        ctrl_d  = '0;
        data_d  = '0;
        err_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!par_ok || !link_ctrl) begin
                        err_d = 1'b1;
                    end else if (!is_local) begin
                        rem_d = flit_cnt;
                        if (flit_cnt != '0) begin
                            state_d = ST_DROP;
                        end
                    end else if (flit_cnt > DEPTH_C) begin
                        err_d   = 1'b1;
                        rem_d   = flit_cnt;
                        state_d = ST_DROP;
                    end else begin
                        hdr_d  = link_payload;
                        cnt_d  = flit_cnt;
                        wcnt_d = '0;
                        if (flit_cnt == '0) begin
                            ctrl_d  = link_payload;
                            state_d = ST_REL_HDR;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
            end

            ST_COLLECT: begin
                if (accept) begin
                    if (link_ctrl || !par_ok || fifo_full ||
                        (flit_src != hdr_q[SRC_HI:SRC_LO])) begin
                        err_d   = 1'b1;
                        flush   = 1'b1;
                        wcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        push = 1'b1;
                        if (wcnt_q + 16'd1 == cnt_q) begin
                            ctrl_d  = hdr_q;
                            wcnt_d  = '0;
                            state_d = ST_REL_HDR;
                        end else begin
                            wcnt_d = wcnt_q + 16'd1;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (accept) begin
                    if (rem_q <= 16'd1) begin
                        rem_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d = rem_q - 16'd1;
                    end
                end
            end

            ST_REL_HDR: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    pop     = !fifo_empty;
                    data_d  = fifo_rdata;
                    wcnt_d  = 16'd1;
                    state_d = ST_REL_DATA;
                end
            end

            ST_REL_DATA: begin
                if (wcnt_q == cnt_q) begin
                    wcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    pop    = !fifo_empty;
                    data_d = fifo_rdata;
                    wcnt_d = wcnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_onoc_rx_interface.sv
// Scoreboard bench for onoc_rx_interface: packet-level reference model feeds
// an expectation queue; a negedge monitor checks every presented item.
module tb_onoc_rx_interface;

    localparam int          DEPTH = 16;
    localparam logic [15:0] NODE  = 16'h0001;

    logic        clk;
    logic        rst;
    logic [15:0] node_id;
    logic        link_valid;
    logic        link_ctrl;
    logic [15:0] link_dest;
    logic [31:0] link_payload;
    logic        link_parity;
    logic        link_ready;
    logic [31:0] control_rx_packet;
    logic [31:0] data_rx_packet;
    logic        rx_err;
    logic        rx_busy;

    typedef struct packed {
        logic        is_ctrl;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    int drv_checks = 0;
    int drv_errors = 0;
    int mon_checks = 0;
    int mon_errors = 0;
    int err_seen   = 0;
    int err_exp    = 0;
    int burst_left = 0;

    onoc_rx_interface #(
        .DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .node_id          (node_id),
        .link_valid       (link_valid),
        .link_ctrl        (link_ctrl),
        .link_dest        (link_dest),
        .link_payload     (link_payload),
        .link_parity      (link_parity),
        .link_ready       (link_ready),
        .control_rx_packet(control_rx_packet),
        .data_rx_packet   (data_rx_packet),
        .rx_err           (rx_err),
        .rx_busy          (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        drv_checks++;
        if (act !== req) begin
            drv_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic mon_item(input logic is_ctrl, input logic [31:0] v);
        exp_t e;
        mon_checks++;
        if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL unexpected_%s: got 0x%08h, expected nothing",
                     is_ctrl ? "ctrl" : "data", v);
        end else begin
            e = exp_q.pop_front();
            if (e.is_ctrl !== is_ctrl || e.val !== v) begin
                mon_errors++;
                $display("FAIL out_item: got %s 0x%08h, expected %s 0x%08h",
                         is_ctrl ? "ctrl" : "data", v, e.is_ctrl ? "ctrl" : "data", e.val);
            end
        end
    endtask

    // Monitor: every non-zero output must be the next expected item, bursts must be gap-free
    always @(negedge clk) begin
        if (!rst) begin
            burst_left = 0;
        end else begin
            if (rx_err) err_seen++;
            if (control_rx_packet != 32'h0) begin
                mon_item(1'b1, control_rx_packet);
                burst_left = int'(control_rx_packet[15:0]);
            end else if (burst_left > 0) begin
                mon_checks++;
                if (data_rx_packet == 32'h0) begin
                    mon_errors++;
                    $display("FAIL burst_gap: got data 0x%08h, expected a word (%0d left)",
                             data_rx_packet, burst_left);
                end
                burst_left--;
            end
            if (data_rx_packet != 32'h0) mon_item(1'b0, data_rx_packet);
            if (control_rx_packet != 32'h0 || data_rx_packet != 32'h0) begin
                mon_checks++;
                if (link_ready !== 1'b0) begin
                    mon_errors++;
                    $display("FAIL ready_in_release: got %0b, expected 0", link_ready);
                end
            end
        end
    end

    // Drive one flit from a negedge; returns at the negedge after it is accepted
    task automatic send_flit(input logic c, input logic [15:0] d, input logic [31:0] p, input logic bad);
        int unsigned n = 0;
        link_valid   = 1'b1;
        link_ctrl    = c;
        link_dest    = d;
        link_payload = p;
        link_parity  = (^{c, d, p}) ^ bad;
        while (!link_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!link_ready) begin
            drv_checks++;
            drv_errors++;
            $display("FAIL ready_timeout: got link_ready=0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
        link_valid = 1'b0;
    endtask

    // mode 0: normal, 1: source mismatch in word 2 (or last), 2: bad header parity
    task automatic send_packet(input logic [15:0] dest, input logic [15:0] src,
                               input int unsigned cnt, input int unsigned mode, input bit fixed);
        logic [31:0] hdr;
        logic [31:0] w;
        bit          local_pkt;
        bit          deliver;
        int unsigned bad_idx;
        hdr       = {src, 16'(cnt)};
        local_pkt = (dest == NODE);
        if (mode == 2) begin
            send_flit(1'b1, dest, hdr, 1'b1);
            err_exp++;
            return;
        end
        deliver = local_pkt && (cnt <= DEPTH) && (mode == 0);
        bad_idx = (cnt > 2) ? 2 : cnt - 1;
        if (local_pkt && cnt > DEPTH) err_exp++;
        if (deliver) exp_q.push_back('{1'b1, hdr});
        send_flit(1'b1, dest, hdr, 1'b0);
        for (int unsigned i = 0; i < cnt; i++) begin
            w = {src, fixed ? 16'(16'hD - i) : 16'($urandom)};
            if (mode == 1 && i == bad_idx) begin
                w[31:16] = src + 16'd1;
                send_flit(1'b0, dest, w, 1'b0);
                err_exp++;
                break;
            end
            if (deliver) exp_q.push_back('{1'b0, w});
            send_flit(1'b0, dest, w, 1'b0);
        end
        if (deliver) begin
            check("ctrl_latency", control_rx_packet, hdr);
            check("ready_low_at_hdr", {31'b0, link_ready}, 32'h0);
        end
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || rx_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 32'h0);
        check({name, "_rx_err_count"}, err_seen, err_exp);
        check({name, "_busy"}, {31'b0, rx_busy}, 32'h0);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] s;
        int unsigned kind;

        rst          = 1'b0;
        node_id      = NODE;
        link_valid   = 1'b0;
        link_ctrl    = 1'b0;
        link_dest    = '0;
        link_payload = '0;
        link_parity  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", control_rx_packet, 32'h0);
        check("rst_data", data_rx_packet, 32'h0);
        check("rst_err", {31'b0, rx_err}, 32'h0);
        check("rst_busy", {31'b0, rx_busy}, 32'h0);
        check("rst_ready", {31'b0, link_ready}, 32'h0);
        rst = 1'b1;
        #1;
        check("ready_after_release", {31'b0, link_ready}, 32'h1);
        @(negedge clk);

        send_packet(NODE, 16'h0001, 4, 0, 1'b1);
        wait_idle("local4");

        send_packet(16'h0002, 16'h0005, 3, 0, 1'b0);
        send_packet(NODE, 16'h0003, 0, 0, 1'b0);
        wait_idle("foreign_then_zero");

        send_packet(NODE, 16'h0004, 17, 0, 1'b0);
        send_packet(NODE, 16'h0004, 3, 0, 1'b0);
        wait_idle("oversize");

        send_packet(NODE, 16'h0001, 4, 1, 1'b0);
        wait_idle("mismatch");

        send_packet(NODE, 16'h0006, DEPTH, 0, 1'b0);
        wait_idle("full_depth");

        send_flit(1'b1, NODE, 32'h0001_0004, 1'b0);
        send_flit(1'b0, NODE, 32'h0001_1111, 1'b0);
        send_flit(1'b0, NODE, 32'h0001_2222, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_ctrl", control_rx_packet, 32'h0);
        check("midrst_data", data_rx_packet, 32'h0);
        check("midrst_busy", {31'b0, rx_busy}, 32'h0);
        check("midrst_ready", {31'b0, link_ready}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready_release", {31'b0, link_ready}, 32'h1);
        @(negedge clk);
        send_packet(NODE, 16'h0007, 4, 0, 1'b0);
        wait_idle("after_reset");

`ifdef ONOC_RX_PARITY_EN
        send_packet(NODE, 16'h0008, 2, 2, 1'b0);
        wait_idle("bad_parity");
        send_packet(NODE, 16'h0008, 2, 0, 1'b0);
        wait_idle("good_parity");
`endif

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            s    = 16'($urandom_range(1, 16'h7FFF));
            d    = 16'($urandom);
            if (d == NODE) d = d ^ 16'h0010;
            case (kind)
                0: send_packet(NODE, s, $urandom_range(0, DEPTH), 0, 1'b0);
                1: send_packet(d, s, $urandom_range(0, 20), 0, 1'b0);
                2: send_packet(NODE, s, $urandom_range(DEPTH + 1, DEPTH + 4), 0, 1'b0);
                3: send_packet(NODE, s, $urandom_range(1, DEPTH), 1, 1'b0);
                default: begin
                    send_flit(1'b0, NODE, {s, 16'($urandom)}, 1'b0);
                    err_exp++;
                end
            endcase
            wait_idle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 drv_checks + mon_checks, drv_errors + mon_errors);
        $finish;
    end

endmodule

// File: doc/onoc_rx_interface.md
# onoc_rx_interface

Receive-side front end between the photonic link receiver and `comms_processor`. It accepts flits from the optical link, keeps only packets addressed to this node, and buffers each packet in full (store-and-forward). It then replays the packet as one `control_rx_packet` cycle followed by back-to-back `data_rx_packet` cycles, so the comms processor always sees a contiguous burst.

## Interface
Parameters:
- DEPTH, 16, data FIFO depth in words; maximum accepted packet length.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- node_id  in  16  this node's ID, static after reset.
- link_valid  in  1  flit present on link.
- link_ctrl  in  1  flit is a header (1) or data word (0).
- link_dest  in  16  destination node of flit.
- link_payload  in  32  header: [31:16] source node, [15:0] word count; data: [31:16] source node, [15:0] data.
- link_parity  in  1  even parity over {link_ctrl, link_dest, link_payload}.
- link_ready  out  1  flit accepted at edge where link_valid & link_ready.
- control_rx_packet  out  32  header to comms_processor, 0 when idle.
- data_rx_packet  out  32  data word to comms_processor, 0 when idle.
- rx_err  out  1  one-cycle error pulse.
- rx_busy  out  1  1 in any state other than IDLE.

## Operation
- FSM states: IDLE, COLLECT, DROP, REL_HDR, REL_DATA. Reset state is IDLE.
- IDLE (link_ready=1):
  - Local header (link_ctrl=1, dest==node_id) with count ≤ DEPTH: latch header and count. Go to REL_HDR if count==0, else COLLECT.
  - Local header with count > DEPTH: pulse rx_err, load remaining=count, go to DROP.
  - Foreign header (dest≠node_id): load remaining=count. Go to DROP if count>0, else stay in IDLE.
  - Data flit: discard it and pulse rx_err.
- COLLECT (link_ready=1):
  - Each data flit is pushed to the FIFO.
  - After the count-th word is pushed, go to REL_HDR.
  - Data flit whose [31:16] ≠ the latched source, or any header flit: pulse rx_err, flush the FIFO, consume the flit, go to IDLE.
- DROP (link_ready=1): consume flits without storing them and decrement remaining. At 0, go to IDLE.
- REL_HDR (link_ready=0): drive control_rx_packet = latched header for one cycle. Then go to REL_DATA if count>0, else IDLE.
- REL_DATA (link_ready=0): pop one word per cycle onto data_rx_packet. After count pops, go to IDLE.
- control_rx_packet and data_rx_packet are registered and return to 0 whenever no item is being presented.
- Count arithmetic is 16-bit unsigned. Remaining-count decrement never wraps below 0.
- Reset, including assertion mid-packet:
  - FIFO flushed, state set to IDLE, all counters cleared.
  - control_rx_packet = 0, data_rx_packet = 0, rx_err = 0, rx_busy = 0.
  - link_ready = 0 while rst=0; 1 in the first cycle after release.

## Timing
- Last data flit (or a count-0 header) accepted at edge k:
  - control_rx_packet is valid in the cycle after edge k.
  - Data word i (0-based) is valid in the cycle after edge k+1+i.
  - link_ready returns to 1 in the cycle after edge k+count+1.
- Count 4 example: four data cycles immediately follow the control cycle, with no bubbles.
- rx_err is asserted in the cycle after the offending edge.
- The FIFO is never read and written in the same cycle, because collect and release are exclusive.
- No back-pressure from comms_processor; the release burst is unconditional.

## Configuration
- ONOC_RX_PARITY_EN defined:
  - Every accepted flit is checked for even parity.
  - Failing header in IDLE: pulse rx_err, discard the flit, stay in IDLE.
  - Failing data flit in COLLECT: same handling as a source mismatch (rx_err, flush, go to IDLE).
  - Failing flit in DROP: consumed as normal.
- ONOC_RX_PARITY_EN undefined: link_parity is ignored and no parity logic is instantiated.

## Structure
- Package onoc_rx_pkg holds:
  - the FSM state enum;
  - header field slices (SRC_HI/LO = 31/16, CNT_HI/LO = 15/0);
  - NODE_W = 16 and FLIT_W = 32.
- Sub-module onoc_rx_fifo: synchronous FIFO, parameter DEPTH, with push, pop, flush, full, empty and pointer wrap-around.
  - Push when full cannot occur by construction; assert against it in simulation.

## Test plan
- Local packet 0x00010004, then words 0x0001000D/0C/0B/0A:
  - Header 0x00010004 for one cycle, then the four words in consecutive cycles.
  - link_ready=0 during release.
- Foreign header (dest=2, count 3) plus 3 words, then local count-0 header 0x00030000:
  - Foreign words are never output.
  - 0x00030000 appears on control_rx_packet; data_rx_packet stays 0.
- Local header with count 17 (DEPTH=16):
  - rx_err pulses and 17 flits are dropped.
  - The next local packet is delivered correctly.
- Local count-4 header from src 1, third word from src 2:
  - rx_err pulses, FIFO is flushed, nothing is released, FSM returns to IDLE.
- rst=0 after 2 words of a count-4 packet:
  - All outputs go to 0 and rx_busy=0.
  - A fresh packet after release is delivered intact.
- With ONOC_RX_PARITY_EN, header with a flipped parity bit:
  - rx_err pulses and no output is produced.
  - The same header with correct parity is delivered.
